// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic {RR = 1'b0, LOCK0 = 1'b1} arb_state_t;
   typedef enum logic {CORE = 1'b0, IO = 1'b1} req_id_t;

   localparam int AW_DEF = 8;
   localparam int DW_DEF = 8;
   localparam int CNT_W  = 16;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin selector: one-hot grant plus the pointer
// to use after this cycle (favours whoever did not just win).
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] elig_i,
   input  req_id_t    ptr_i,
   output logic [1:0] gnt_o,
   output req_id_t    ptr_o
);

   always_comb begin
      gnt_o = 2'b00;
      ptr_o = ptr_i;
      if (elig_i == 2'b11) begin
         gnt_o = (ptr_i == CORE) ? 2'b01 : 2'b10;
      end else begin
         gnt_o = elig_i;
      end
      if (gnt_o[0]) begin
         ptr_o = IO;
      end else if (gnt_o[1]) begin
         ptr_o = CORE;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one 256x8 SRAM between the core LSU (port 0) and the I/O engine (port 1).
// Define DMEM_ARB_STATS_EN to add the saturating conflict_cnt_o contention counter.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0_i,
   input  logic          we0_i,
   input  logic [AW-1:0] addr0_i,
   input  logic [DW-1:0] wdata0_i,
   input  logic          lock0_i,
   input  logic          req1_i,
   input  logic          we1_i,
   input  logic [AW-1:0] addr1_i,
   input  logic [DW-1:0] wdata1_i,
   output logic          gnt0_o,
   output logic          gnt1_o,
   output logic          rvalid0_o,
   output logic          rvalid1_o,
   output logic [DW-1:0] rdata0_o,
   output logic [DW-1:0] rdata1_o,
   output logic          mem_en_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0] conflict_cnt_o
`endif
);

   arb_state_t    state_q, state_d;
   req_id_t       ptr_q, ptr_d;
   logic [1:0]    gnt_q;
   logic [1:0]    rvld_q;
   logic          mem_en_q, mem_we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;

   logic [1:0]    elig, pick;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   // A request still visible during its own grant pulse must not win again.
   assign elig[0] = req0_i & ~gnt_q[0];
   assign elig[1] = req1_i & ~gnt_q[1] & (state_q == RR);

   rr_pick2 u_pick (
      .elig_i (elig),
      .ptr_i  (ptr_q),
      .gnt_o  (pick),
      .ptr_o  (ptr_d)
   );

   always_comb begin
      state_d   = state_q;
      sel_we    = we0_i;
      sel_addr  = addr0_i;
      sel_wdata = wdata0_i;
      if (pick[0]) begin
         state_d = lock0_i ? LOCK0 : RR;
      end
      if (pick[1]) begin
         sel_we    = we1_i;
         sel_addr  = addr1_i;
         sel_wdata = wdata1_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RR;
         ptr_q    <= CORE;
         gnt_q    <= 2'b00;
         rvld_q   <= 2'b00;
         mem_en_q <= 1'b0;
         mem_we_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gnt_q    <= pick;
         mem_en_q <= |pick;
         if (|pick) begin
            mem_we_q <= sel_we;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
         end
         // The grant pulse doubles as the owner tag for the read now at the SRAM.
         rvld_q   <= gnt_q & {2{mem_en_q & ~mem_we_q}};
      end
   end

   assign gnt0_o      = gnt_q[0];
   assign gnt1_o      = gnt_q[1];
   assign mem_en_o    = mem_en_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign rvalid0_o   = rvld_q[0];
   assign rvalid1_o   = rvld_q[1];
   assign rdata0_o    = rvld_q[0] ? mem_rdata_i : '0;
   assign rdata1_o    = rvld_q[1] ? mem_rdata_i : '0;

`ifdef DMEM_ARB_STATS_EN
   logic [CNT_W-1:0] cnt_q;
   logic             conflict;

   assign conflict = (&elig) | ((state_q == LOCK0) & req1_i & ~gnt_q[1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (conflict && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign conflict_cnt_o = cnt_q;
`endif

endmodule
